// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package rv32i_fetch_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PC_STEP   = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/rv32i_fetch_skid_buf.sv
// One-entry IF/ID skid buffer: catches a fetch response that lands while IF/ID is stalled.
module rv32i_fetch_skid_buf
  import rv32i_fetch_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_push,
  input  logic   i_pop,
  input  logic   i_flush,
  input  if_id_t i_data,
  output if_id_t o_data,
  output logic   o_full
);

  if_id_t data_q;
  logic   full_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      full_q <= 1'b0;
      data_q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
    end else if (i_push) begin
      full_q <= 1'b1;
      data_q <= i_data;
    end else if (i_pop) begin
      full_q <= 1'b0;
    end
  end

  assign o_data = data_q;
  assign o_full = full_q;

endmodule

// File: rtl/rv32i_fetch_unit.sv
// IF stage: owns the PC, issues single-outstanding fetches and drives the IF/ID register.
// Optional misaligned-redirect trap enabled by defining RV32I_FETCH_MISALIGN_TRAP_EN.
module rv32i_fetch_unit
  import rv32i_fetch_pkg::*;
#(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_pc_sel,
  input  logic [WIDTH-1:0] i_target_pc,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [WIDTH-1:0] i_imem_rdata,
  output logic             o_if_valid,
  output logic [WIDTH-1:0] o_if_pc,
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
  output logic             o_if_misaligned,
`endif
  output logic [WIDTH-1:0] o_if_instr
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, req_pc_q, req_pc_d, target;
  logic             discard_q, discard_d, park_q, park_d;
  logic             resp, deliver, push, pop, full_next, skid_full;
  logic             req, accept, outstanding, misalign;
  if_id_t           ifid_q, ifid_d, skid_in, skid_out;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
  assign target   = i_target_pc;
  assign misalign = i_pc_sel && (i_target_pc[1:0] != 2'b00);
`else
  assign target   = i_target_pc & ~WIDTH'(3);
  assign misalign = 1'b0;
`endif

  assign resp      = i_imem_rvalid && (state_q == S_WAIT);
  assign deliver   = resp && !discard_q && !i_pc_sel;
  assign pop       = !i_pc_sel && !i_stall && skid_full;
  assign push      = deliver && (i_stall || skid_full);
  assign full_next = !i_pc_sel && (push || (skid_full && !pop));
  assign skid_in   = '{valid: 1'b1, pc: req_pc_q, instr: i_imem_rdata};

  rv32i_fetch_skid_buf u_skid (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (push),
    .i_pop  (pop),
    .i_flush(i_pc_sel),
    .i_data (skid_in),
    .o_data (skid_out),
    .o_full (skid_full)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    discard_d   = discard_q;
    park_d      = park_q;
    req         = 1'b0;
    outstanding = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (discard_q && i_imem_rvalid) discard_d = 1'b0;
        if (!park_q) state_d = S_REQ;
      end
      S_REQ:  req = !full_next;
      S_WAIT: begin
        // The response cycle may launch the next fetch so 1-cycle memory streams.
        if (i_imem_rvalid) begin
          discard_d = 1'b0;
          req       = deliver && !full_next;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    accept = req && i_imem_gnt;
    if (accept) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + WIDTH'(PC_STEP);
      state_d  = S_WAIT;
    end
    if (i_pc_sel) begin
      // Anything still in flight after this edge belongs to the wrong path.
      outstanding = accept
                 || ((state_q == S_WAIT) && !i_imem_rvalid)
                 || ((state_q == S_IDLE) && discard_q && !i_imem_rvalid);
      pc_d      = target;
      discard_d = outstanding;
      park_d    = misalign;
      if (misalign)         state_d = S_IDLE;
      else if (outstanding) state_d = S_WAIT;
      else                  state_d = S_REQ;
    end
  end

  always_comb begin
    ifid_d = ifid_q;
    if (i_pc_sel) begin
      if (misalign) ifid_d = '{valid: 1'b1, pc: target, instr: NOP_INSTR};
      else          ifid_d = '{valid: 1'b0, pc: ifid_q.pc, instr: NOP_INSTR};
    end else if (!i_stall) begin
      if (skid_full)    ifid_d = skid_out;
      else if (deliver) ifid_d = skid_in;
      else              ifid_d = '{valid: 1'b0, pc: ifid_q.pc, instr: NOP_INSTR};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      discard_q <= 1'b0;
      park_q    <= 1'b0;
      ifid_q    <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
      park_q    <= park_d;
      ifid_q    <= ifid_d;
    end
  end

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
  logic mis_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)         mis_q <= 1'b0;
    else if (i_pc_sel) mis_q <= misalign;
    else if (!i_stall) mis_q <= 1'b0;
  end

  assign o_if_misaligned = mis_q;
`endif

  assign o_imem_req  = req;
  assign o_imem_addr = pc_q;
  assign o_if_valid  = ifid_q.valid;
  assign o_if_pc     = ifid_q.pc;
  assign o_if_instr  = ifid_q.instr;

endmodule
